dac_wave_gen: RTL and testbench

DAC_WAVE_GEN -- requirements
Module: dac_wave_gen

---
 rtl/dac_wave_gen_pkg.sv | 26 ++
 rtl/dac_wave_lfsr.sv | 28 ++
 rtl/dac_wave_gen.sv | 182 ++++++++++++++++++
 tb/tb_dac_wave_gen.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_wave_gen_pkg.sv
// Shared types and constants for the DAC waveform generator.
// Mode/state encodings and the dither LFSR seed and taps.
package dac_wave_gen_pkg;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_SAW   = 2'd1,
        MODE_TRI   = 2'd2,
        MODE_SQR   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_fb(input logic [15:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/dac_wave_lfsr.sv
// 16-bit Fibonacci LFSR used to dither the sample LSB.
// Reloads its seed on reset or load, steps once per adv.
module dac_wave_lfsr
    import dac_wave_gen_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic adv,
    output logic bit0
);

    logic [15:0] q;

    // Shift register: seed on reset/load, shift on advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else if (load) begin
            q <= LFSR_SEED;
        end else if (adv) begin
            q <= {q[14:0], lfsr_fb(q)};
        end
    end

    assign bit0 = q[0];

endmodule

// File: rtl/dac_wave_gen.sv
// Burst waveform generator feeding a DAC FIFO.
// Define DAC_WAVE_GEN_DITHER_EN to XOR an LFSR bit into data[0].
module dac_wave_gen
    import dac_wave_gen_pkg::*;
#(
    parameter int DW = 10,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    input  logic          stop,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] lo,
    input  logic [DW-1:0] hi,
    input  logic [DW-1:0] step,
    input  logic [CW-1:0] count,
    input  logic          fifo_low,
    output logic [DW-1:0] data,
    output logic          wr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_e        state;
    state_e        state_nx;
    mode_e         mode_q;
    logic [DW-1:0] lo_q;
    logic [DW-1:0] hi_q;
    logic [DW-1:0] step_q;
    logic          cont_q;
    logic [CW-1:0] rem;
    logic [DW-1:0] cur;
    logic [DW-1:0] cur_nx;
    logic          dir_dn;
    logic          dir_nx;
    logic [DW:0]   up_sum;
    logic [DW:0]   lo_sum;
    logic [DW-1:0] sample;
    logic          accept;
    logic          reject;
    logic          emit;
    logic          last;

    assign accept = (state == ST_IDLE) && start && (lo <= hi);
    assign reject = (state == ST_IDLE) && start && (lo > hi);
    assign emit   = (state == ST_RUN) && en && fifo_low && !stop;
    assign last   = emit && !cont_q && (rem == CW'(1));

`ifdef DAC_WAVE_GEN_DITHER_EN
    logic dith;

    dac_wave_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .adv  (emit),
        .bit0 (dith)
    );

    assign sample = {cur[DW-1:1], cur[0] ^ dith};
`else
    assign sample = cur;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; stop beats a same-cycle emission
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (accept) state_nx = ST_RUN;
            ST_RUN: begin
                if (stop) begin
                    state_nx = ST_IDLE;
                end else if (last) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state == ST_RUN);
    end

    // Next sample and direction, computed one bit wider
    always_comb begin
        up_sum = {1'b0, cur} + {1'b0, step_q};
        lo_sum = {1'b0, lo_q} + {1'b0, step_q};
        cur_nx = lo_q;
        dir_nx = dir_dn;
        unique case (1'b1)
            mode_q == MODE_CONST: begin
                cur_nx = lo_q;
            end
            mode_q == MODE_SAW: begin
                if (up_sum > {1'b0, hi_q}) begin
                    cur_nx = lo_q;
                end else begin
                    cur_nx = up_sum[DW-1:0];
                end
            end
            mode_q == MODE_TRI: begin
                if (!dir_dn) begin
                    if (up_sum >= {1'b0, hi_q}) begin
                        cur_nx = hi_q;
                        dir_nx = 1'b1;
                    end else begin
                        cur_nx = up_sum[DW-1:0];
                    end
                end else begin
                    if ({1'b0, cur} < lo_sum) begin
                        cur_nx = lo_q;
                        dir_nx = 1'b0;
                    end else begin
                        cur_nx = cur - step_q;
                    end
                end
            end
            mode_q == MODE_SQR: begin
                cur_nx = dir_dn ? lo_q : hi_q;
                dir_nx = !dir_dn;
            end
            default: begin
                cur_nx = lo_q;
            end
        endcase
    end

    // Datapath: latch config on start, emit one sample per qualifying edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data   <= '0;
            wr     <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            cur    <= '0;
            dir_dn <= 1'b0;
            rem    <= '0;
            mode_q <= MODE_CONST;
            lo_q   <= '0;
            hi_q   <= '0;
            step_q <= '0;
            cont_q <= 1'b0;
        end else begin
            wr   <= emit;
            err  <= reject;
            done <= (state == ST_DONE);
            if (accept) begin
                mode_q <= mode_e'(mode);
                lo_q   <= lo;
                hi_q   <= hi;
                step_q <= step;
                cont_q <= (count == '0);
                rem    <= count;
                cur    <= lo;
                dir_dn <= 1'b0;
            end else if (emit) begin
                data   <= sample;
                cur    <= cur_nx;
                dir_dn <= dir_nx;
                if (!cont_q) begin
                    rem <= rem - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_wave_gen.sv
// Self-checking bench for dac_wave_gen: behavioural model
// compared every cycle plus literal expected sample lists.
module tb_dac_wave_gen;

    localparam int DW = 10;
    localparam int CW = 16;
`ifdef DAC_WAVE_GEN_DITHER_EN
    localparam int MASK = 'h3FE;
`else
    localparam int MASK = 'h3FF;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] lo = '0;
    logic [DW-1:0] hi = '0;
    logic [DW-1:0] step = '0;
    logic [CW-1:0] count = '0;
    logic          fifo_low = 1'b1;
    logic [DW-1:0] data;
    logic          wr;
    logic          busy;
    logic          done;
    logic          err;

    dac_wave_gen #(.DW(DW), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .lo       (lo),
        .hi       (hi),
        .step     (step),
        .count    (count),
        .fifo_low (fifo_low),
        .data     (data),
        .wr       (wr),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 run, 2 done
    int m_st = 0;
    int m_mode, m_lo, m_hi, m_step, m_cur, m_rem;
    bit m_up, m_cont;
`ifdef DAC_WAVE_GEN_DITHER_EN
    int m_lfsr = 'hACE1;
    int fb;
`endif
    bit x_wr, x_done, x_err, x_busy;
    int x_data;

    int cap[$];
    int done_cnt = 0;
    int err_cnt = 0;

    // Model step on each edge, then compare 1 time unit later
    always @(posedge clk) begin
        if (rst) begin
            m_st = 0; x_wr = 0; x_done = 0; x_err = 0;
            m_cur = 0; m_up = 1; m_rem = 0;
`ifdef DAC_WAVE_GEN_DITHER_EN
            m_lfsr = 'hACE1;
`endif
        end else begin
            x_wr = 0; x_done = 0; x_err = 0;
            if (m_st == 0) begin
                if (start) begin
                    if (lo <= hi) begin
                        m_mode = mode; m_lo = lo; m_hi = hi;
                        m_step = step; m_cur = lo; m_up = 1;
                        m_rem = count; m_cont = (count == 0);
                        m_st = 1;
`ifdef DAC_WAVE_GEN_DITHER_EN
                        m_lfsr = 'hACE1;
`endif
                    end else begin
                        x_err = 1;
                    end
                end
            end else if (m_st == 1) begin
                if (stop) begin
                    m_st = 0;
                end else if (en && fifo_low) begin
                    x_wr = 1;
                    x_data = m_cur;
`ifdef DAC_WAVE_GEN_DITHER_EN
                    x_data = m_cur ^ (m_lfsr & 1);
                    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13)
                        ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
                    m_lfsr = ((m_lfsr << 1) | fb) & 'hFFFF;
`endif
                    case (m_mode)
                        0: m_cur = m_lo;
                        1: m_cur = (m_cur + m_step > m_hi)
                                   ? m_lo : m_cur + m_step;
                        2: begin
                            if (m_up) begin
                                if (m_cur + m_step >= m_hi) begin
                                    m_cur = m_hi; m_up = 0;
                                end else m_cur += m_step;
                            end else begin
                                if (m_cur < m_lo + m_step) begin
                                    m_cur = m_lo; m_up = 1;
                                end else m_cur -= m_step;
                            end
                        end
                        default: begin
                            m_cur = m_up ? m_hi : m_lo;
                            m_up = !m_up;
                        end
                    endcase
                    if (!m_cont) begin
                        m_rem--;
                        if (m_rem == 0) m_st = 2;
                    end
                end
            end else begin
                x_done = 1;
                m_st = 0;
            end
        end
        x_busy = (m_st == 1);
        #1;
        chk("wr", int'(wr), int'(x_wr));
        chk("busy", int'(busy), int'(x_busy));
        chk("done", int'(done), int'(x_done));
        chk("err", int'(err), int'(x_err));
        if (x_wr) chk("data", int'(data), x_data);
        if (wr) cap.push_back(int'(data));
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go(input int md, input int l, input int h,
                      input int s, input int c);
        @(negedge clk);
        mode = 2'(md); lo = DW'(l); hi = DW'(h);
        step = DW'(s); count = CW'(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int base = done_cnt;
        int n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_seen"}, done_cnt - base, 1);
    endtask

    task automatic check_cap(input string name, input int exp[$]);
        chk({name, "_len"}, cap.size(), exp.size());
        for (int i = 0; i < exp.size() && i < cap.size(); i++)
            chk(name, cap[i] & MASK, exp[i] & MASK);
    endtask

    initial begin
        int d0;
        int e0;
        cyc(2);
        chk("rst_data", int'(data), 0);
        chk("rst_wr", int'(wr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;

        // Sawtooth, inputs changed after start must be ignored
        cap.delete();
        go(1, 100, 130, 10, 6);
        lo = 3; step = 7;
        wait_done("saw", 40);
        check_cap("saw", '{100, 110, 120, 130, 100, 110});
        chk("saw_busy_end", int'(busy), 0);

        // Triangle with an ignored start mid-run
        cap.delete();
        e0 = err_cnt;
        go(2, 0, 25, 10, 7);
        cyc(1);
        lo = 30; hi = 5; start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_done("tri", 40);
        check_cap("tri", '{0, 10, 20, 25, 15, 5, 0});
        chk("tri_no_err", err_cnt - e0, 0);

        // Continuous square, fifo_low toggling, then stop
        cap.delete();
        d0 = done_cnt;
        fifo_low = 1'b0;
        go(3, 0, 1023, 0, 0);
        for (int i = 0; i < 14; i++) begin
            fifo_low = ~fifo_low;
            cyc(1);
        end
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        fifo_low = 1'b1;
        chk("sqr_busy_after_stop", int'(busy), 0);
        chk("sqr_cap_len", cap.size(), 7);
        for (int i = 0; i < cap.size(); i++)
            chk("sqr", cap[i] & MASK, ((i % 2) ? 1023 : 0) & MASK);
        cyc(3);
        chk("sqr_no_done", done_cnt - d0, 0);

        // Rejected start
        cap.delete();
        e0 = err_cnt;
        go(0, 500, 400, 0, 3);
        cyc(3);
        chk("rej_err", err_cnt - e0, 1);
        chk("rej_busy", int'(busy), 0);
        chk("rej_wr_count", cap.size(), 0);

        // Reset mid-burst
        cap.delete();
        d0 = done_cnt;
        go(1, 0, 1000, 5, 10);
        for (int n = 0; cap.size() < 3 && n < 40; n++) cyc(1);
        chk("mid_rst_reached", cap.size(), 3);
        #2 rst = 1'b1;
        #1;
        chk("mrst_data", int'(data), 0);
        chk("mrst_wr", int'(wr), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_err", int'(err), 0);
        cyc(2);
        rst = 1'b0;
        chk("mrst_no_done", done_cnt - d0, 0);
        cap.delete();
        go(1, 0, 1000, 5, 2);
        wait_done("restart", 20);
        check_cap("restart", '{0, 5});

        // Enable freezes emission
        cap.delete();
        go(1, 0, 50, 20, 4);
        en = 1'b0; cyc(3);
        en = 1'b1; cyc(1);
        en = 1'b0; cyc(2);
        en = 1'b1;
        wait_done("en", 40);
        check_cap("en", '{0, 20, 40, 0});

        // Stop on an emission edge: no write, no done
        cap.delete();
        d0 = done_cnt;
        go(1, 0, 100, 30, 0);
        cyc(2);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(2);
        chk("stop_busy", int'(busy), 0);
        chk("stop_no_done", done_cnt - d0, 0);
        check_cap("stop", '{0, 30});

        // Boundary cases
        cap.delete();
        go(0, 77, 200, 9, 3);
        wait_done("const", 20);
        check_cap("const", '{77, 77, 77});

        cap.delete();
        go(1, 40, 90, 0, 3);
        wait_done("saw_s0", 20);
        check_cap("saw_s0", '{40, 40, 40});

        cap.delete();
        go(2, 300, 300, 50, 4);
        wait_done("tri_eq", 20);
        check_cap("tri_eq", '{300, 300, 300, 300});

        cap.delete();
        go(3, 10, 20, 0, 5);
        wait_done("sqr5", 20);
        check_cap("sqr5", '{10, 20, 10, 20, 10});

        cap.delete();
        go(1, 1000, 1023, 1023, 3);
        wait_done("saw_ovf", 20);
        check_cap("saw_ovf", '{1000, 1000, 1000});

        cap.delete();
        go(2, 0, 1023, 1000, 5);
        wait_done("tri_ovf", 20);
        check_cap("tri_ovf", '{0, 1000, 1023, 23, 0});

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
